bram_rd_stream: RTL

Read-side streaming controller for a `bram_1r1w` instance: converts a valid/ready address-request stream into an in-order valid/ready data-response stream. Drives the BRAM read address and hides its one-cycle registered read latency behind a 2-entry response buffer, sustaining one read per cycle under no backpressure. It monitors the BRAM write enable and blocks reads in write cycles, because write-first mode returns write data instead of the addressed word when a write is active.

---
 rtl/bram_rd_stream.sv | 89 ++++++++
 1 files changed

// File: rtl/bram_rd_stream.sv
// Streaming read front-end for a registered-output 1R1W BRAM: valid/ready address requests in, in-order data responses out.
// Optional BRAM_RD_STREAM_ADDR_ECHO_EN adds resp_addr, echoing the address of the word on resp_data.
module bram_rd_stream #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
`ifdef BRAM_RD_STREAM_ADDR_ECHO_EN
  output logic [ADDR_WIDTH-1:0] resp_addr,
`endif
  input  logic                  bram_wr_en,
  output logic [ADDR_WIDTH-1:0] bram_rd_addr,
  input  logic [DATA_WIDTH-1:0] bram_rd_data
);

  logic                  inflight_q;
  logic [1:0]            count_q, count_d;
  logic                  rd_ptr_q, wr_ptr_q;
  logic [DATA_WIDTH-1:0] data_q [2];
  logic                  pop, accept, push;
  logic [1:0]            occ;

  assign bram_rd_addr = req_addr;
  assign resp_valid   = (count_q != 2'd0);
  assign resp_data    = data_q[rd_ptr_q];
  assign pop          = resp_valid && resp_ready;
  assign push         = inflight_q;

  // Slots committed after this cycle: buffered words plus the word in the BRAM pipe, minus the one leaving.
  assign occ       = count_q + {1'b0, inflight_q} - {1'b0, pop};
  assign req_ready = !bram_wr_en && (occ < 2'd2);
  assign accept    = req_valid && req_ready;

  always_comb begin
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      data_q[0]  <= '0;
      data_q[1]  <= '0;
    end else begin
      inflight_q <= accept;
      count_q    <= count_d;
      if (push) begin
        data_q[wr_ptr_q] <= bram_rd_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

`ifdef BRAM_RD_STREAM_ADDR_ECHO_EN
  // Address of the word in the BRAM pipe, then a FIFO sharing the data FIFO's pointers.
  logic [ADDR_WIDTH-1:0] addr_pipe_q;
  logic [ADDR_WIDTH-1:0] addr_q [2];

  assign resp_addr = addr_q[rd_ptr_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_pipe_q <= '0;
      addr_q[0]   <= '0;
      addr_q[1]   <= '0;
    end else begin
      if (accept) begin
        addr_pipe_q <= req_addr;
      end
      if (push) begin
        addr_q[wr_ptr_q] <= addr_pipe_q;
      end
    end
  end
`endif

endmodule
